param_vec_driver: RTL and testbench
===================================

Name: param_vec_driver

Overview:
- Parameterized transmitter that generates the vector consumed by width-parameterized receiver modules, such as the bsize-wide input port of the coverage diagnostics.
- It replaces hand-sequenced initial-block stimulus with a clocked pattern generator.
- A valid/ready handshake paces each vector out.
- It is instantiated once per receiver width, e.g. BSIZE=2 and BSIZE=3 side by side.

Parameters:
- BSIZE, 1, width of the transmitted vector (>=1).
- CNTW, 8, width of the transfer-count request and sent counter.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a burst; sampled only in IDLE.
- mode  input  2  pattern select, latched on accepted start.
- count  input  CNTW  number of vectors in the burst, latched on accepted start.
- b_out  output  BSIZE  transmitted vector.
- b_valid  output  1  b_out holds a vector to transfer.
- b_ready  input  1  receiver accepts the vector this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on burst completion.
- sent  output  CNTW  vectors transferred in the current/last burst.

Behaviour:
- Reset (reset low, asynchronous) clears state to IDLE and sets b_out=0, b_valid=0, busy=0, done=0, sent=0, internal remaining=0, pattern=0.
- Reset mid-burst aborts immediately. No done pulse is generated. After release the block sits in IDLE.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 latches mode and count, clears sent, loads the seed pattern (below) into b_out.
  - count=0 goes to FIN. Otherwise go to RUN with remaining=count.
- RUN:
  - b_valid=1, busy=1.
  - A transfer occurs on a cycle with b_valid & b_ready.
  - On each transfer: sent+=1, remaining-=1, and b_out advances to the next pattern on the following cycle.
  - Transfer with remaining==1 goes to FIN and drops b_valid the next cycle.
- While b_valid=1 and b_ready=0, b_out, sent and remaining hold stable. There is no time-out.
- FIN: done=1 for exactly one cycle, b_valid=0, busy=0, then IDLE. sent retains the final value until the next accepted start.
- start while in RUN or FIN is ignored and not queued.
- Latency:
  - start in IDLE at edge N gives b_valid=1 at N+1.
  - With b_ready held high, one vector per cycle, so a burst of K takes K cycles in RUN plus one FIN cycle.
- Patterns (all arithmetic modulo 2^BSIZE, wrap silently):
  - mode 0 INC: seed 0, next = b+1.
  - mode 1 WALK1: seed 1 (bit0), next = rotate-left by 1. BSIZE=1 stays 1.
  - mode 2 ALT: seed all-zeros, next = ~b.
  - mode 3 GRAY: internal binary counter c seeded 0, b_out = c ^ (c>>1), next c = c+1.
- sent saturates at all-ones. It cannot exceed count since remaining bounds it.
- Mode and count changes during RUN have no effect.

Decomposition:
- Shared defines/package param_vec_defs holds:
  - Mode encodings MODE_INC=0, MODE_WALK1=1, MODE_ALT=2, MODE_GRAY=3.
  - State encodings S_IDLE=0, S_RUN=1, S_FIN=2 (2-bit).
- One natural sub-module, param_vec_pattern:
  - Combinational, parameterized by BSIZE.
  - Inputs: mode, current binary state. Outputs: seed value and next value, plus the Gray conversion.
  - Keeps the FSM/handshake logic in param_vec_driver free of pattern arithmetic.

Test Plan:
- BSIZE=2, mode 0, count=5, b_ready=1 -> b_out 0,1,2,3,0 on consecutive cycles; sent=5; done pulses one cycle after the last transfer.
- BSIZE=3, mode 3, count=8, b_ready=1 -> b_out 000,001,011,010,110,111,101,100; sent=8.
- BSIZE=3, mode 1, count=4, b_ready toggling 1,0,1,0,... -> b_out 001,010,100,001; each value held through the ready-low cycles; transfers only on ready-high; sent=4.
- BSIZE=2, mode 2, count=0 -> no b_valid assertion; done pulses the cycle after start; sent=0.
- BSIZE=2, mode 0, count=10, reset low after the 3rd transfer -> all outputs 0 asynchronously, no done; start is ignored while busy, and a new start after reset release begins a fresh burst from 0.

Source files
------------

// File: rtl/param_vec_driver_pkg.sv
// Shared encodings for the parameterized vector driver and its pattern helper.
package param_vec_driver_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_WALK1 = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_GRAY  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/param_vec_driver_pattern.sv
// Combinational pattern arithmetic: seed and successor of the internal
// binary state, plus the vector actually driven (Gray-coded in GRAY mode).
module param_vec_pattern
  import param_vec_driver_pkg::*;
#(
  parameter int BSIZE = 1
) (
  input  mode_e            mode_i,
  input  logic [BSIZE-1:0] cur_i,
  output logic [BSIZE-1:0] seed_o,
  output logic [BSIZE-1:0] next_o,
  output logic [BSIZE-1:0] seed_vec_o,
  output logic [BSIZE-1:0] next_vec_o
);

  localparam logic [BSIZE-1:0] ONE = BSIZE'(1);

  // Seed and next binary state per mode; all arithmetic wraps at 2^BSIZE.
  always_comb begin
    seed_o = '0;
    next_o = cur_i + ONE;
    case (mode_i)
      MODE_INC: begin
        seed_o = '0;
        next_o = cur_i + ONE;
      end
      MODE_WALK1: begin
        // Rotate-left; with BSIZE=1 the two shifted terms collapse to cur_i.
        seed_o = ONE;
        next_o = (cur_i << 1) | (cur_i >> (BSIZE - 1));
      end
      MODE_ALT: begin
        seed_o = '0;
        next_o = ~cur_i;
      end
      MODE_GRAY: begin
        seed_o = '0;
        next_o = cur_i + ONE;
      end
      default: begin
        seed_o = '0;
        next_o = cur_i + ONE;
      end
    endcase
  end

  // Map binary state to the driven vector; only GRAY differs from identity.
  always_comb begin
    seed_vec_o = seed_o;
    next_vec_o = next_o;
    if (mode_i == MODE_GRAY) begin
      seed_vec_o = seed_o ^ (seed_o >> 1);
      next_vec_o = next_o ^ (next_o >> 1);
    end
  end

endmodule

// File: rtl/param_vec_driver.sv
// Clocked pattern transmitter: emits a burst of BSIZE-wide vectors over a
// valid/ready handshake, one vector per accepted transfer.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; sent holds the last burst's total
// S_RUN  | b_valid high, advancing the pattern on each transfer
// S_FIN  | one-cycle done pulse, then back to S_IDLE
module param_vec_driver
  import param_vec_driver_pkg::*;
#(
  parameter int BSIZE = 1,
  parameter int CNTW  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNTW-1:0]  count,
  output logic [BSIZE-1:0] b_out,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  sent
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_e           state_q;
  mode_e            mode_q;
  logic [CNTW-1:0]  rem_q;
  logic [CNTW-1:0]  sent_q;
  logic [BSIZE-1:0] pat_q;
  logic [BSIZE-1:0] b_out_q;
  logic             b_valid_q;
  logic             busy_q;
  logic             done_q;

  mode_e            pat_mode;
  logic [BSIZE-1:0] seed_bin;
  logic [BSIZE-1:0] next_bin;
  logic [BSIZE-1:0] seed_vec;
  logic [BSIZE-1:0] next_vec;
  logic             xfer;

  // In IDLE the seed must follow the incoming mode; afterwards the latched one.
  always_comb begin
    pat_mode = mode_q;
    if (state_q == S_IDLE) pat_mode = mode_e'(mode);
    xfer = b_valid_q & b_ready;
  end

  param_vec_pattern #(.BSIZE(BSIZE)) u_pattern (
    .mode_i     (pat_mode),
    .cur_i      (pat_q),
    .seed_o     (seed_bin),
    .next_o     (next_bin),
    .seed_vec_o (seed_vec),
    .next_vec_o (next_vec)
  );

  // Burst sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_INC;
      rem_q     <= '0;
      sent_q    <= '0;
      pat_q     <= '0;
      b_out_q   <= '0;
      b_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q  <= mode_e'(mode);
            sent_q  <= '0;
            pat_q   <= seed_bin;
            b_out_q <= seed_vec;
            if (count == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              rem_q     <= count;
              b_valid_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            pat_q   <= next_bin;
            b_out_q <= next_vec;
            rem_q   <= rem_q - CNT_ONE;
            if (!(&sent_q)) sent_q <= sent_q + CNT_ONE;
            if (rem_q == CNT_ONE) begin
              state_q   <= S_FIN;
              b_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          b_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign b_out   = b_out_q;
  assign b_valid = b_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sent    = sent_q;

endmodule

// File: tb/tb_param_vec_driver.sv
// Bench for param_vec_driver: a BSIZE=2 and a BSIZE=3 instance side by side,
// checked against a closed-form model of the k-th vector of each pattern.
module tb_param_vec_driver;

  logic       clk;
  logic       rst_n;

  logic       st2, rdy2, bv2, busy2, done2;
  logic [1:0] md2;
  logic [7:0] cnt2, sent2;
  logic [1:0] bo2;

  logic       st3, rdy3, bv3, busy3, done3;
  logic [1:0] md3;
  logic [7:0] cnt3, sent3;
  logic [2:0] bo3;

  int n_checks = 0;
  int n_errors = 0;

  param_vec_driver #(.BSIZE(2), .CNTW(8)) u_dut2 (
    .clock(clk), .reset(rst_n), .start(st2), .mode(md2), .count(cnt2),
    .b_out(bo2), .b_valid(bv2), .b_ready(rdy2), .busy(busy2), .done(done2),
    .sent(sent2)
  );

  param_vec_driver #(.BSIZE(3), .CNTW(8)) u_dut3 (
    .clock(clk), .reset(rst_n), .start(st3), .mode(md3), .count(cnt3),
    .b_out(bo3), .b_valid(bv3), .b_ready(rdy3), .busy(busy3), .done(done3),
    .sent(sent3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // k-th vector of a burst, straight from the pattern definitions.
  function automatic int unsigned model_vec(input int bsize, input int md, input int k);
    int unsigned m = 1 << bsize;
    int unsigned g;
    case (md)
      0: return k % m;
      1: return 1 << (k % bsize);
      2: return (k % 2 == 1) ? m - 1 : 0;
      default: begin
        g = k % m;
        return g ^ (g >> 1);
      end
    endcase
  endfunction

  task automatic set_in(input int which, input logic st, input int md, input int cnt, input logic rdy);
    if (which == 2) begin
      st2 = st; md2 = md[1:0]; cnt2 = cnt[7:0]; rdy2 = rdy;
    end else begin
      st3 = st; md3 = md[1:0]; cnt3 = cnt[7:0]; rdy3 = rdy;
    end
  endtask

  task automatic sample(input int which, output logic [31:0] bo, output logic [31:0] bv,
                        output logic [31:0] by, output logic [31:0] dn, output logic [31:0] sn);
    if (which == 2) begin
      bo = {30'd0, bo2}; bv = {31'd0, bv2}; by = {31'd0, busy2};
      dn = {31'd0, done2}; sn = {24'd0, sent2};
    end else begin
      bo = {29'd0, bo3}; bv = {31'd0, bv3}; by = {31'd0, busy3};
      dn = {31'd0, done3}; sn = {24'd0, sent3};
    end
  endtask

  // rdy_pol: 0 always ready, 1 toggling starting high, 2 random.
  // abort_at >= 0 pulls reset low once that many transfers have happened.
  task automatic run_burst(input int which, input int md, input int cnt,
                           input int rdy_pol, input int abort_at);
    int k = 0;
    int cyc = 0;
    int bsize = (which == 2) ? 2 : 3;
    logic rdy;
    logic [31:0] bo, bv, by, dn, sn;
    @(negedge clk);
    set_in(which, 1'b1, md, cnt, 1'b0);
    @(posedge clk);
    @(negedge clk);
    while (k < cnt && cyc < 300) begin
      sample(which, bo, bv, by, dn, sn);
      check("run_valid", bv, 1);
      check("run_busy", by, 1);
      check("run_bout", bo, model_vec(bsize, md, k));
      check("run_sent", sn, k);
      check("run_done", dn, 0);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        sample(which, bo, bv, by, dn, sn);
        check("abort_bout", bo, 0);
        check("abort_valid", bv, 0);
        check("abort_busy", by, 0);
        check("abort_done", dn, 0);
        check("abort_sent", sn, 0);
        set_in(which, 1'b1, md, cnt, 1'b1);
        @(negedge clk);
        set_in(which, 1'b0, md, cnt, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          sample(which, bo, bv, by, dn, sn);
          check("post_abort_done", dn, 0);
          check("post_abort_valid", bv, 0);
          check("post_abort_busy", by, 0);
        end
        return;
      end
      case (rdy_pol)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      // Stray starts with junk mode/count while busy must have no effect.
      set_in(which, ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
             $urandom_range(0, 255), rdy);
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) check("burst_timeout", 1, 0);
    sample(which, bo, bv, by, dn, sn);
    check("fin_done", dn, 1);
    check("fin_valid", bv, 0);
    check("fin_busy", by, 0);
    check("fin_sent", sn, cnt);
    set_in(which, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    sample(which, bo, bv, by, dn, sn);
    check("idle_done", dn, 0);
    check("idle_valid", bv, 0);
    check("idle_busy", by, 0);
    check("idle_sent", sn, cnt);
  endtask

  initial begin
    logic [31:0] bo, bv, by, dn, sn;
    rst_n = 1'b0;
    set_in(2, 1'b0, 0, 0, 1'b0);
    set_in(3, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    for (int w = 2; w <= 3; w++) begin
      sample(w, bo, bv, by, dn, sn);
      check("reset_bout", bo, 0);
      check("reset_valid", bv, 0);
      check("reset_busy", by, 0);
      check("reset_done", dn, 0);
      check("reset_sent", sn, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(2, 0, 5, 0, -1);
    run_burst(3, 3, 8, 0, -1);
    run_burst(3, 1, 4, 1, -1);
    run_burst(2, 2, 0, 0, -1);
    run_burst(2, 0, 10, 0, 3);
    run_burst(2, 0, 4, 0, -1);
    run_burst(3, 2, 5, 1, -1);
    run_burst(2, 1, 3, 0, -1);

    for (int t = 0; t < 30; t++) begin
      run_burst(($urandom_range(0, 1) == 0) ? 2 : 3, $urandom_range(0, 3),
                $urandom_range(0, 12), $urandom_range(0, 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
